// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, bubble encoding and fetch FSM states for the fetch stage
package if_stage_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_REQ   = 2'd1,
        IF_DRAIN = 2'd2,
        IF_HOLD  = 2'd3
    } if_state_e;

    // Sequential successor of a fetch address; wraps modulo 2^32
    function automatic logic [INST_ADDR_W-1:0] next_seq(input logic [INST_ADDR_W-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID boundary register with bubble (highest priority), load and implicit hold
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bubble,
    input  logic                   load,
    input  logic [INST_ADDR_W-1:0] next_pc,
    input  logic [INST_W-1:0]      next_inst,
    output logic [INST_ADDR_W-1:0] pc,
    output logic [INST_W-1:0]      inst,
    output logic                   valid
);

    // Bubble clears, load captures, otherwise the contents are held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (bubble) begin
            pc    <= '0;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= next_pc;
            inst  <= next_inst;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, imem req/ready fetch FSM, one-entry skid buffer and IF/ID register.
// Optional macro IF_STAGE_DELAY_SLOT_EN keeps the word completing with a redirect (MIPS delay slot).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_ready_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   valid_o
);

`ifdef IF_STAGE_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    if_state_e              state, state_nxt;
    logic [INST_ADDR_W-1:0] fetch_addr, fetch_addr_nxt, redir_addr, buf_pc;
    logic [INST_W-1:0]      buf_inst;
    logic                   br, capture, deliver, take, park;

    // Next state, next fetch address and what happens to the completing word
    always_comb begin
        br             = branch_flag_i & ~stall_i;
        state_nxt      = state;
        fetch_addr_nxt = fetch_addr;
        capture        = 1'b0;
        deliver        = 1'b0;
        case (state)
            IF_BOOT: state_nxt = IF_REQ;
            IF_REQ: begin
                if (imem_ready_i) begin
                    capture        = ~br | DELAY_SLOT;
                    fetch_addr_nxt = br ? branch_target_i : next_seq(fetch_addr);
                end else if (br) begin
                    state_nxt = IF_DRAIN;
                end
            end
            IF_DRAIN: begin
                if (imem_ready_i) begin
                    capture        = DELAY_SLOT;
                    fetch_addr_nxt = br ? branch_target_i : redir_addr;
                    state_nxt      = IF_REQ;
                end
            end
            IF_HOLD: begin
                deliver        = ~stall_i & (~br | DELAY_SLOT);
                fetch_addr_nxt = br ? branch_target_i : fetch_addr;
                state_nxt      = (~stall_i | flush_i) ? IF_REQ : IF_HOLD;
            end
        endcase
        if (park) state_nxt = IF_HOLD;
    end

    assign park        = capture & stall_i & ~flush_i;
    assign take        = capture | deliver;
    assign imem_req_o  = (state == IF_REQ) | (state == IF_DRAIN);
    assign imem_addr_o = fetch_addr;

    // FSM state and fetch address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IF_BOOT;
            fetch_addr <= RESET_PC;
        end else begin
            state      <= state_nxt;
            fetch_addr <= fetch_addr_nxt;
        end
    end

    // Latest honoured redirect target; only consumed when leaving DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) redir_addr <= '0;
        else if (br) redir_addr <= branch_target_i;
    end

    // Skid buffer catches a word that completes while decode is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_pc   <= '0;
            buf_inst <= NOP_INST;
        end else if (park) begin
            buf_pc   <= fetch_addr;
            buf_inst <= imem_rdata_i;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .bubble    (flush_i | (~stall_i & ~take)),
        .load      (~flush_i & ~stall_i & take),
        .next_pc   (state == IF_HOLD ? buf_pc : fetch_addr),
        .next_inst (state == IF_HOLD ? buf_inst : imem_rdata_i),
        .pc        (pc_o),
        .inst      (inst_o),
        .valid     (valid_o)
    );

endmodule
